// File: rtl/lm70_multi_reader.sv
// Round-robin poller for up to four LM70-style SPI temperature sensors on a shared SCK/SIO bus.
// Publishes each valid 11-bit reading with a strobe and keeps a per-channel alarm with hysteresis.
module lm70_multi_reader #(
  parameter int NUM_CH     = 2,
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 4,
  parameter int HYST       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sio,
  input  logic [8:0]        hi_thresh,
  output logic [NUM_CH-1:0] cs_n,
  output logic              sck,
  output logic              valid,
  output logic [1:0]        ch_id,
  output logic [10:0]       temp_q,
  output logic [8:0]        temp_int,
  output logic              frame_err,
  output logic [NUM_CH-1:0] alarm
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH, GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  CH_LAST  = 2'(NUM_CH - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [4:0]  falls, falls_nxt;
  logic [1:0]  ch, ch_nxt;
  logic        sck_nxt, shift_en;
  logic [15:0] shreg;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    falls_nxt = falls;
    sck_nxt   = sck;
    ch_nxt    = ch;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        sck_nxt = 1'b0;
        if (enable) state_nxt = SETUP;
      end
      SETUP: if (cnt == DIV_LAST) begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        falls_nxt = '0;
      end
      SHIFT: if (cnt == DIV_LAST) begin
        cnt_nxt = '0;
        sck_nxt = ~sck;
        // sio is captured on the same edge that raises sck
        if (!sck) shift_en = 1'b1;
        else begin
          falls_nxt = falls + 5'd1;
          if (falls == 5'd15) state_nxt = HOLD;
        end
      end
      HOLD: if (cnt == DIV_LAST) begin
        state_nxt = LATCH;
        cnt_nxt   = '0;
      end
      LATCH: begin
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
      GAP: if (cnt == GAP_LAST) begin
        cnt_nxt   = '0;
        ch_nxt    = (ch == CH_LAST) ? 2'd0 : ch + 2'd1;
        state_nxt = enable ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      cs_n[i] = !((state == SETUP || state == SHIFT || state == HOLD) && ch == 2'(i));
  end

  logic               frame_ok;
  logic signed [9:0]  new_t, th, th_lo;
  assign frame_ok = (shreg[4:0] == 5'h1F);
  assign new_t    = $signed({shreg[15], shreg[15:7]});
  assign th       = $signed({hi_thresh[8], hi_thresh});
  assign th_lo    = th - 10'sd1 * HYST[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      falls     <= '0;
      ch        <= '0;
      sck       <= 1'b0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      ch_id     <= '0;
      temp_q    <= '0;
      temp_int  <= '0;
      alarm     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      falls     <= falls_nxt;
      ch        <= ch_nxt;
      sck       <= sck_nxt;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (shift_en) shreg <= {shreg[14:0], sio};
      if (state == LATCH) begin
        ch_id <= ch;
        if (frame_ok) begin
          valid    <= 1'b1;
          temp_q   <= shreg[15:5];
          temp_int <= shreg[15:7];
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 2'(i)) begin
              if (new_t >= th)         alarm[i] <= 1'b1;
              else if (new_t < th_lo)  alarm[i] <= 1'b0;
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end
endmodule
